fsab_rr_arbiter: RTL

- Next-generation FSAB request arbiter. Sits between N per-device request buffers and the single outbound FSAB request bus.
- Grants the bus with either round-robin (fair) or fixed-priority selection and tracks outbound FSAB credits.
- Routes the owning device's flattened request word onto the bus and masks stale valids.
- Per-device buffers expose ready/active/start handshakes. This block owns selection, credits and the output mux.

---
 rtl/fsab_rr_arbiter_pkg.sv | 41 ++++
 rtl/fsab_rr_pick.sv | 42 ++++
 rtl/fsab_rr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fsab_rr_arbiter_pkg.sv
// Shared FSAB definitions: request field layout, credit defaults, arbiter
// state encoding and a constant-safe clog2 helper.
package fsab_defines;

    // Field HI bits, each relative to its own field.
    localparam int FSAB_REQ_HI    = 0;
    localparam int FSAB_DID_HI    = 3;
    localparam int FSAB_SUBDID_HI = 3;
    localparam int FSAB_ADDR_HI   = 30;
    localparam int FSAB_LEN_HI    = 2;
    localparam int FSAB_DATA_HI   = 63;
    localparam int FSAB_MASK_HI   = 7;

    // Packed request word layout, LSB first: mask, data, len, addr, subdid, did, mode.
    localparam int FSAB_MASK_OFS   = 0;
    localparam int FSAB_DATA_OFS   = FSAB_MASK_OFS + FSAB_MASK_HI + 1;
    localparam int FSAB_LEN_OFS    = FSAB_DATA_OFS + FSAB_DATA_HI + 1;
    localparam int FSAB_ADDR_OFS   = FSAB_LEN_OFS + FSAB_LEN_HI + 1;
    localparam int FSAB_SUBDID_OFS = FSAB_ADDR_OFS + FSAB_ADDR_HI + 1;
    localparam int FSAB_DID_OFS    = FSAB_SUBDID_OFS + FSAB_SUBDID_HI + 1;
    localparam int FSAB_MODE_OFS   = FSAB_DID_OFS + FSAB_DID_HI + 1;

    localparam int FSAB_INITIAL_CREDITS = 8;
    localparam int FSAB_CREDITS_HI      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_OWN  = 2'd2
    } arb_state_t;

    function automatic int fsab_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fsab_rr_pick.sv
// Combinational picker: first ready index after i_rr_ptr (rotating) when
// i_mode=1, otherwise the highest ready index.
module fsab_rr_pick #(
    parameter int DEVICES = 4,
    parameter int DEV_W   = 2
) (
    input  logic [DEVICES-1:0] i_ready,
    input  logic [DEV_W-1:0]   i_rr_ptr,
    input  logic               i_mode,
    output logic               o_any,
    output logic [DEV_W-1:0]   o_index
);

    int   w_cand;
    int   w_sel;
    logic w_hit;
    logic w_found;

    assign o_any   = |i_ready;
    assign o_index = DEV_W'(w_sel);

    // Scan candidates in priority order; the first ready one wins.
    always_comb begin
        w_cand  = 0;
        w_sel   = 0;
        w_hit   = 1'b0;
        w_found = 1'b0;
        for (int k = 0; k < DEVICES; k++) begin
            if (i_mode) begin
                w_cand = (int'(i_rr_ptr) + 1 + k) % DEVICES;
            end else begin
                w_cand = DEVICES - 1 - k;
            end
            w_hit = |(i_ready & (DEVICES'(1) << w_cand));
            if (!w_found && w_hit) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fsab_rr_arbiter.sv
// FSAB request arbiter: grants the outbound bus to one device at a time,
// tracks outbound credits and muxes the owner's request word onto the bus.
module fsab_rr_arbiter
    import fsab_defines::*;
#(
    parameter int FSAB_DEVICES    = 4,
    parameter int REQ_W           = 128,
    parameter int RR_MODE         = 1,
    parameter int CREDIT_W        = FSAB_CREDITS_HI + 1,
    parameter int INITIAL_CREDITS = FSAB_INITIAL_CREDITS,
    parameter int DEV_W           = fsab_clog2((FSAB_DEVICES > 2) ? FSAB_DEVICES : 2)
) (
    input  logic                          clk,
    input  logic                          Nrst,
    input  logic [FSAB_DEVICES-1:0]       dev_ready,
    input  logic [FSAB_DEVICES-1:0]       dev_active,
    input  logic [FSAB_DEVICES-1:0]       dev_valid,
    input  logic [FSAB_DEVICES*REQ_W-1:0] dev_req,
    output logic [FSAB_DEVICES-1:0]       dev_start,
    input  logic                          fsabo_credit,
    output logic                          fsabo_valid,
    output logic [REQ_W-1:0]              fsabo_req,
    output logic [DEV_W-1:0]              cur_dev,
    output logic [CREDIT_W-1:0]           credits,
    output logic                          credit_err
);

    arb_state_t          r_state;
    logic [DEV_W-1:0]    r_cur_dev;
    logic [DEV_W-1:0]    r_rr_ptr;
    logic [CREDIT_W-1:0] r_credits;
    logic                r_credit_err;

    logic                w_any;
    logic [DEV_W-1:0]    w_pick_idx;
    logic                w_owner_active;
    logic                w_grant;
    logic [REQ_W-1:0]    w_req_arr [FSAB_DEVICES];

    fsab_rr_pick #(
        .DEVICES (FSAB_DEVICES),
        .DEV_W   (DEV_W)
    ) u_pick (
        .i_ready  (dev_ready),
        .i_rr_ptr (r_rr_ptr),
        .i_mode   (RR_MODE != 0),
        .o_any    (w_any),
        .o_index  (w_pick_idx)
    );

    assign w_owner_active = dev_active[r_cur_dev];

    // Handover is allowed in the same cycle the owner drops active; Nrst
    // gating keeps start pulses quiet while reset is held.
    assign w_grant = Nrst && w_any && (r_credits != '0) &&
                     ((r_state == ST_IDLE) || ((r_state == ST_OWN) && !w_owner_active));

    for (genvar gi = 0; gi < FSAB_DEVICES; gi++) begin : g_dev
        assign w_req_arr[gi] = dev_req[gi*REQ_W +: REQ_W];
        assign dev_start[gi] = w_grant && (w_pick_idx == DEV_W'(gi));
    end

    assign fsabo_req   = w_req_arr[r_cur_dev];
    assign fsabo_valid = dev_valid[r_cur_dev] && w_owner_active && (r_state != ST_IDLE);
    assign cur_dev     = r_cur_dev;
    assign credits     = r_credits;
    assign credit_err  = r_credit_err;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state      <= ST_IDLE;
            r_cur_dev    <= '0;
            r_rr_ptr     <= DEV_W'(FSAB_DEVICES - 1);
            r_credits    <= CREDIT_W'(INITIAL_CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_grant) r_state <= ST_ARM;
                ST_ARM:  r_state <= w_owner_active ? ST_OWN : ST_IDLE;
                ST_OWN:  if (!w_owner_active) r_state <= w_grant ? ST_ARM : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_grant) begin
                r_cur_dev <= w_pick_idx;
                r_rr_ptr  <= w_pick_idx;
            end

            // A return and a grant in the same cycle cancel out.
            if (fsabo_credit && !w_grant) begin
                if (r_credits == '1) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + 1'b1;
                end
            end else if (!fsabo_credit && w_grant) begin
                r_credits <= r_credits - 1'b1;
            end
        end
    end

endmodule
